// File: rtl/load_store_unit_if.sv
// Core request/response channel and word-memory channel of the load/store unit.
// Latency: none (signal bundle only).
// Backpressure: req_ready_o toward the core, mem_gnt_i from memory; responses are never stalled.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    // core side
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_we_i;
    logic [XLEN-1:0] req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic [1:0]      req_size_i;
    logic            req_sign_ext_i;
    logic            resp_valid_o;
    logic [XLEN-1:0] resp_rdata_o;
    logic            resp_err_o;

    // word-memory side
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    // view taken by the load/store unit itself
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_sign_ext_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    // view taken by the surrounding core and memory
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_sign_ext_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Shared architectural constants for the core.
// Latency: n/a.
// Backpressure: n/a.
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

// Byte/half/word load-store unit over a word-organised memory, splitting misaligned accesses in two.
// Latency: aligned 3 cycles handshake-to-resp_valid_o, split 5, rejected request 1 (plus memory stalls).
// Backpressure: one request in flight (req_ready_o only in IDLE); waits on mem_gnt_i/mem_rvalid_i; no response stall.
module load_store_unit #(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int MEM_BYTES = 8192
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // request as captured on the handshake
    typedef struct packed {
        logic            we;
        logic            sign_ext;
        logic [1:0]      size;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // one bit wider than the address so that addr + nbytes never wraps
    localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    state_t          state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic            split_q, split_d;
    logic [XLEN-1:0] word0_q, word0_d;
    logic [XLEN-1:0] word1_q, word1_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    // incoming request decode
    logic [2:0]      in_nbytes;
    logic            in_split;
    logic [XLEN:0]   in_end;
    logic            in_err;

    // lane placement of the captured request
    logic [3:0]        mask;
    logic [7:0]        be_wide;
    logic [2*XLEN-1:0] wdata_wide;
    logic [XLEN-1:0]   word_addr;
    logic [XLEN-1:0]   word_addr_next;

    // memory-side drive
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;

    // Pick the addressed bytes out of the {word1,word0} pair and extend them to XLEN.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2*XLEN-1:0] pair,
        input logic [1:0]        off,
        input logic [1:0]        size,
        input logic              sext
    );
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   res;
        sh = pair >> {off, 3'b000};
        unique case (size)
            2'b00:   res = {{(XLEN-8){sext & sh[7]}}, sh[7:0]};
            2'b01:   res = {{(XLEN-16){sext & sh[15]}}, sh[15:0]};
            default: res = sh[XLEN-1:0];
        endcase
        return res;
    endfunction

    // Size, split and range check of the request currently offered by the core.
    always_comb begin
        unique case (bus.req_size_i)
            2'b00:   in_nbytes = 3'd1;
            2'b01:   in_nbytes = 3'd2;
            default: in_nbytes = 3'd4;
        endcase
        in_split = ({1'b0, bus.req_addr_i[1:0]} + in_nbytes) > 3'd4;
        in_end   = {1'b0, bus.req_addr_i} + {{(XLEN-2){1'b0}}, in_nbytes};
        in_err   = (bus.req_size_i == 2'b11) || (in_end > MEM_LIMIT);
    end

    // Byte enables and write data shifted into lanes across the two-word window.
    always_comb begin
        unique case (req_q.size)
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        be_wide        = {4'b0000, mask} << req_q.addr[1:0];
        wdata_wide     = {{XLEN{1'b0}}, req_q.wdata} << {req_q.addr[1:0], 3'b000};
        word_addr      = {req_q.addr[XLEN-1:2], 2'b00};
        word_addr_next = word_addr + XLEN'(4);
    end

    // Next-state, captured data and memory drive; memory outputs stay 0 unless requesting.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        split_d   = split_q;
        word0_d   = word0_q;
        word1_d   = word1_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = 4'b0000;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    req_d.we       = bus.req_we_i;
                    req_d.sign_ext = bus.req_sign_ext_i;
                    req_d.size     = bus.req_size_i;
                    req_d.addr     = bus.req_addr_i;
                    req_d.wdata    = bus.req_wdata_i;
                    split_d        = in_split;
                    word0_d        = '0;
                    word1_d        = '0;
                    rdata_d        = '0;
                    err_d          = in_err;
                    // a rejected request never touches memory
                    state_d        = in_err ? RESP : REQ0;
                end
            end
            REQ0: begin
                mem_req   = 1'b1;
                mem_we    = req_q.we;
                mem_addr  = word_addr;
                mem_be    = be_wide[3:0];
                mem_wdata = wdata_wide[XLEN-1:0];
                if (bus.mem_gnt_i) begin
                    state_d = WAIT0;
                end
            end
            WAIT0: begin
                if (bus.mem_rvalid_i) begin
                    word0_d = bus.mem_rdata_i;
                    if (split_q) begin
                        state_d = REQ1;
                    end else begin
                        // word1 is still the zero cleared at the handshake
                        rdata_d = req_q.we ? '0
                                : load_extract({word1_d, word0_d}, req_q.addr[1:0],
                                               req_q.size, req_q.sign_ext);
                        state_d = RESP;
                    end
                end
            end
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = req_q.we;
                mem_addr  = word_addr_next;
                mem_be    = be_wide[7:4];
                mem_wdata = wdata_wide[2*XLEN-1:XLEN];
                if (bus.mem_gnt_i) begin
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (bus.mem_rvalid_i) begin
                    word1_d = bus.mem_rdata_i;
                    rdata_d = req_q.we ? '0
                            : load_extract({word1_d, word0_d}, req_q.addr[1:0],
                                           req_q.size, req_q.sign_ext);
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured request/response registers; reset drops any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            split_q <= 1'b0;
            word0_q <= '0;
            word1_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            split_q <= split_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;
    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_addr_o   = mem_addr;
    assign bus.mem_be_o     = mem_be;
    assign bus.mem_wdata_o  = mem_wdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN (32), data/address width.
REQ-002 SHALL have parameter MEM_BYTES, default 8192, size of the addressable data space in bytes.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i  input  1  rising-edge clock.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 req_valid_i  input  1  core request valid.
REQ-006 req_ready_o  output  1  unit accepts a request this cycle.
REQ-007 req_we_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  XLEN  byte address, any alignment.
REQ-009 req_wdata_i  input  XLEN  store data, right-justified.
REQ-010 req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_sign_ext_i  input  1  load sign-extend (1) / zero-extend (0).
REQ-012 resp_valid_o  output  1  one-cycle completion pulse.
REQ-013 resp_rdata_o  output  XLEN  load result, extended; 0 for stores and errors.
REQ-014 resp_err_o  output  1  request rejected, qualified by resp_valid_o.
REQ-015 mem_req_o  output  1  word-memory request.
REQ-016 mem_we_o  output  1  word-memory write.
REQ-017 mem_addr_o  output  XLEN  word-aligned address, bits [1:0] always 0.
REQ-018 mem_be_o  output  4  byte enables, bit i = byte lane i.
REQ-019 mem_wdata_o  output  XLEN  lane-aligned write data.
REQ-020 mem_gnt_i  input  1  memory accepted mem_req_o this cycle.
REQ-021 mem_rvalid_i  input  1  response/ack for a granted access, loads and stores alike.
REQ-022 mem_rdata_i  input  XLEN  read word, valid with mem_rvalid_i.

Function
REQ-023 SHALL implement the FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
REQ-024 req_ready_o SHALL be 1 exactly when the state is IDLE; a handshake is req_valid_i & req_ready_o; address, data, size, sign and we SHALL be registered on the handshake.
REQ-025 On handshake: off = addr[1:0]; nbytes = 1/2/4; split = (off + nbytes > 4).
REQ-026 Errors SHALL be: size 11, or addr + nbytes > MEM_BYTES computed without truncation.
REQ-027 On an error the FSM SHALL go IDLE->RESP with no memory access; otherwise it SHALL go IDLE->REQ0.
REQ-028 REQ0: mem_req_o=1, mem_addr_o={addr[XLEN-1:2],2'b00}, mem_be_o=(mask<<off)[3:0], mem_wdata_o=(wdata<<8*off)[31:0]; mask=0001/0011/1111; stay until mem_gnt_i, then WAIT0.
REQ-029 REQ1: same, with address +4, be=(mask<<off)[7:4] and wdata=(wdata<<8*off)[63:32]; stay until mem_gnt_i, then WAIT1.
REQ-030 WAIT0 SHALL capture mem_rdata_i as word0 on mem_rvalid_i, then go to REQ1 if split, else RESP; WAIT1 SHALL capture word1 and go to RESP.
REQ-031 The load result SHALL be ({word1,word0} >> 8*off) truncated to nbytes, then sign- or zero-extended per req_sign_ext_i; when not split, word1 SHALL be treated as 0.
REQ-032 RESP SHALL hold resp_valid_o=1 for exactly one cycle, then return to IDLE; resp_rdata_o and resp_err_o SHALL be registered and stable during the pulse; there is no response back-pressure.
REQ-033 Outside REQ0/REQ1, mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o SHALL be 0.
REQ-034 mem_rvalid_i outside WAIT0/WAIT1 SHALL be ignored; mem_gnt_i and mem_rvalid_i asserting together with a request SHALL NOT skip a state.
REQ-035 Minimum latency: aligned access 3 cycles handshake-to-resp_valid_o (gnt in REQ0, rvalid in the first WAIT0 cycle); split access 5 cycles; error 1 cycle.
REQ-036 Split stores SHALL write lower-address lanes first; a wrap of the second word past MEM_BYTES is impossible because REQ-026 rejects it.

Reset
REQ-037 rst_ni low SHALL force IDLE asynchronously at any state, including mid-split.
REQ-038 During and after reset: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, all mem_* outputs=0, and captured words cleared.
REQ-039 A memory response pending across reset SHALL be ignored.

Verification
REQ-040 Aligned load word: memory word 0x10 = 0xDEADBEEF, load size 10 addr 0x10 -> one access with be 1111 addr 0x10; resp_rdata_o=0xDEADBEEF 3 cycles after handshake.
REQ-041 Split signed half load: mem 0x0C=0xAA000000, 0x10=0x00000080, load size 01 sign 1 addr 0x0F -> accesses 0x0C be 1000 then 0x10 be 0001; resp_rdata_o=0xFFFF80AA.
REQ-042 Split store word: addr 0x1E, data 0x11223344 -> 0x1C be 1100 wdata 0x33440000, then 0x20 be 0011 wdata 0x00001122; resp_rdata_o=0, err 0.
REQ-043 Errors: size 11 at 0x0, and word at 0x1FFE -> resp_err_o=1 one cycle after handshake, mem_req_o never asserted; word at 0x1FFC -> no error.
REQ-044 Back-pressure and reset: mem_gnt_i held low 4 cycles in REQ0 -> mem_req_o and address stable; then assert rst_ni low in WAIT1 -> next cycle IDLE, req_ready_o=1, no resp_valid_o pulse.
